// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem req/ready handshake, registered IF outputs.
// Optional bubble counter output enabled by FETCH_BUBBLE_CNT_EN.
module fetch_stage #(
  parameter int              ADDR_W   = 32,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid
`ifdef FETCH_BUBBLE_CNT_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   pc, pc_n, pc_inc, tgt;
  logic [ADDR_W-1:0]   if_pc_n, hold_pc, hold_pc_n, pend_pc, pend_pc_n;
  logic [INST_W-1:0]   if_inst_n, hold_inst, hold_inst_n;
  logic                if_valid_n;

  assign pc_inc    = pc + ADDR_W'(4);
  assign tgt       = redirect_pc & ALIGN_MASK;
  assign imem_addr = pc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= BOOT;
    else        state <= state_n;
  end

  // Redirect wins over everything; a redirect against an outstanding request parks in DRAIN.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    if_pc_n     = if_pc;
    if_inst_n   = if_inst;
    if_valid_n  = if_valid;
    hold_pc_n   = hold_pc;
    hold_inst_n = hold_inst;
    pend_pc_n   = pend_pc;
    case (state)
      BOOT: begin
        state_n = FETCH;
        if (redirect_valid) pc_n = tgt;
      end
      FETCH: begin
        if (redirect_valid) begin
          if_valid_n = 1'b0;
          if (imem_ready) begin
            pc_n = tgt;
          end else begin
            pend_pc_n = tgt;
            state_n   = DRAIN;
          end
        end else if (imem_ready) begin
          pc_n = pc_inc;
          if (stall) begin
            hold_pc_n   = pc;
            hold_inst_n = imem_rdata;
            state_n     = HOLD;
          end else begin
            if_pc_n    = pc;
            if_inst_n  = imem_rdata;
            if_valid_n = 1'b1;
          end
        end else if (!stall) begin
          if_valid_n = 1'b0;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          if_valid_n = 1'b0;
          pc_n       = tgt;
          state_n    = FETCH;
        end else if (!stall) begin
          if_pc_n    = hold_pc;
          if_inst_n  = hold_inst;
          if_valid_n = 1'b1;
          state_n    = FETCH;
        end
      end
      DRAIN: begin
        if_valid_n = 1'b0;
        if (redirect_valid) pend_pc_n = tgt;
        if (imem_ready) begin
          pc_n    = redirect_valid ? tgt : pend_pc;
          state_n = FETCH;
        end
      end
      default: state_n = BOOT;
    endcase
  end

  always_comb begin
    imem_req = (state == FETCH) || (state == DRAIN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc        <= RESET_PC & ALIGN_MASK;
      if_pc     <= '0;
      if_inst   <= '0;
      if_valid  <= 1'b0;
      hold_pc   <= '0;
      hold_inst <= '0;
      pend_pc   <= '0;
    end else begin
      pc        <= pc_n;
      if_pc     <= if_pc_n;
      if_inst   <= if_inst_n;
      if_valid  <= if_valid_n;
      hold_pc   <= hold_pc_n;
      hold_inst <= hold_inst_n;
      pend_pc   <= pend_pc_n;
    end
  end

`ifdef FETCH_BUBBLE_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bubble_cnt <= '0;
    end else if (state != BOOT && !stall && !if_valid_n && bubble_cnt != 16'hFFFF) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage (cycle vectors + streaming scoreboard).
// Covers FETCH_BUBBLE_CNT_EN when that macro is defined.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        stall, redirect_valid, imem_ready;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_inst;
  logic        if_valid;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_rdata, w_pc, w_inst;
`ifdef FETCH_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt, w_bub;
  int          bub_exp;
`endif

  int checks = 0;
  int errors = 0;
  logic        sb_en = 1'b0;
  logic        aw_pending = 1'b0;
  logic [31:0] aw_addr;
  logic [31:0] sbq[$];

  always #5 CLK = ~CLK;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  assign imem_rdata = imem_ready ? pat(imem_addr) : 32'hDEAD_BEEF;
  assign w_rdata    = pat(w_addr);

  fetch_stage u_dut (
    .CLK(CLK), .RST_N(RST_N), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
`ifdef FETCH_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .CLK(CLK), .RST_N(RST_N), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(w_rdata),
    .if_pc(w_pc), .if_inst(w_inst), .if_valid(w_valid)
`ifdef FETCH_BUBBLE_CNT_EN
    , .bubble_cnt(w_bub)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        s, r, rv;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input string n, input logic s, input logic r, input logic rv,
                              input logic [31:0] rpc, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.name = n; v.s = s; v.r = r; v.rv = rv; v.rpc = rpc;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  // Consumption happens on an edge where if_valid=1 and stall=0, like the IF/ID register.
  always @(negedge CLK) begin
    if (sb_en) begin
      if (aw_pending) chk("addr_stable", imem_addr, aw_addr);
      aw_pending = imem_req && !imem_ready;
      aw_addr    = imem_addr;
      if (if_valid && !stall) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual_pc=%h expected=none", if_pc);
        end else begin
          logic [31:0] e;
          e = sbq.pop_front();
          chk("sb_pc", if_pc, e);
          chk("sb_inst", if_inst, pat(e));
        end
      end
    end
  end

  logic [31:0] wrap_exp[3];

  initial begin
    RST_N = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0;

    tv.push_back(mk("boot",      0,1,0,32'h0,   1,32'h0,  0,32'h0));
    tv.push_back(mk("first",     0,1,0,32'h0,   1,32'h4,  1,32'h0));
    tv.push_back(mk("seq4",      0,1,0,32'h0,   1,32'h8,  1,32'h4));
    tv.push_back(mk("seq8",      0,1,0,32'h0,   1,32'hC,  1,32'h8));
    tv.push_back(mk("seqc",      0,1,0,32'h0,   1,32'h10, 1,32'hC));
    tv.push_back(mk("stall1",    1,1,0,32'h0,   0,32'h14, 1,32'hC));
    tv.push_back(mk("stall2",    1,1,0,32'h0,   0,32'h14, 1,32'hC));
    tv.push_back(mk("stall3",    1,1,0,32'h0,   0,32'h14, 1,32'hC));
    tv.push_back(mk("hold_out",  0,1,0,32'h0,   1,32'h14, 1,32'h10));
    tv.push_back(mk("after_h",   0,1,0,32'h0,   1,32'h18, 1,32'h14));
    tv.push_back(mk("redir200",  0,1,1,32'h200, 1,32'h200,0,32'h0));
    tv.push_back(mk("at200",     0,1,0,32'h0,   1,32'h204,1,32'h200));
    tv.push_back(mk("redir40",   0,1,1,32'h40,  1,32'h40, 0,32'h0));
    tv.push_back(mk("wait_rd",   0,0,1,32'h100, 1,32'h40, 0,32'h0));
    tv.push_back(mk("drain",     0,0,0,32'h0,   1,32'h40, 0,32'h0));
    tv.push_back(mk("drain_end", 0,1,0,32'h0,   1,32'h100,0,32'h0));
    tv.push_back(mk("at100",     0,1,0,32'h0,   1,32'h104,1,32'h100));
    tv.push_back(mk("to_hold",   1,1,0,32'h0,   0,32'h108,1,32'h100));
    tv.push_back(mk("hold_rd",   1,1,1,32'h300, 1,32'h300,0,32'h0));
    tv.push_back(mk("at300",     0,1,0,32'h0,   1,32'h304,1,32'h300));
    tv.push_back(mk("mem_wait",  0,0,0,32'h0,   1,32'h304,0,32'h0));
    tv.push_back(mk("stall_bub", 1,0,0,32'h0,   1,32'h304,0,32'h0));
    tv.push_back(mk("at304",     0,1,0,32'h0,   1,32'h308,1,32'h304));
    tv.push_back(mk("redir_mis", 0,1,1,32'h403, 1,32'h400,0,32'h0));
    tv.push_back(mk("at400",     0,1,0,32'h0,   1,32'h404,1,32'h400));
    tv.push_back(mk("drain_a",   0,0,1,32'h500, 1,32'h404,0,32'h0));
    tv.push_back(mk("drain_b",   0,0,1,32'h600, 1,32'h404,0,32'h0));
    tv.push_back(mk("drain_c",   0,1,0,32'h0,   1,32'h600,0,32'h0));
    tv.push_back(mk("at600",     0,1,0,32'h0,   1,32'h604,1,32'h600));

    @(posedge CLK); #1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
`ifdef FETCH_BUBBLE_CNT_EN
    chk("rst_bub", {16'b0, bubble_cnt}, 32'h0);
    bub_exp = 0;
`endif
    RST_N = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      stall = tv[i].s; imem_ready = tv[i].r;
      redirect_valid = tv[i].rv; redirect_pc = tv[i].rpc;
      @(posedge CLK); #1;
      chk({tv[i].name, "_req"}, {31'b0, imem_req}, {31'b0, tv[i].e_req});
      chk({tv[i].name, "_addr"}, imem_addr, tv[i].e_addr);
      chk({tv[i].name, "_valid"}, {31'b0, if_valid}, {31'b0, tv[i].e_valid});
      if (tv[i].e_valid) begin
        chk({tv[i].name, "_pc"}, if_pc, tv[i].e_pc);
        chk({tv[i].name, "_inst"}, if_inst, pat(tv[i].e_pc));
      end
      if (i >= 1 && i <= 3) begin
        chk("wrap_valid", {31'b0, w_valid}, 32'h1);
        chk("wrap_pc", w_pc, wrap_exp[i-1]);
      end
`ifdef FETCH_BUBBLE_CNT_EN
      if (i != 0 && !tv[i].s && !tv[i].e_valid) bub_exp++;
      chk({tv[i].name, "_bub"}, {16'b0, bubble_cnt}, 32'(bub_exp));
`endif
    end

    stall = 1'b0; imem_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h1000;
    @(posedge CLK); #1;
    redirect_valid = 1'b0;
    chk("sb_start_valid", {31'b0, if_valid}, 32'h0);
    for (int k = 0; k < 40; k++) sbq.push_back(32'h1000 + 32'(4 * k));
    aw_pending = 1'b0;
    sb_en = 1'b1;
    for (int c = 0; c < 3000 && sbq.size() != 0; c++) begin
      stall = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      @(posedge CLK); #1;
    end
    sb_en = 1'b0;
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    stall = 1'b0; imem_ready = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    chk("mid_rst_valid", {31'b0, if_valid}, 32'h0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rerun_boot_valid", {31'b0, if_valid}, 32'h0);
    @(posedge CLK); #1;
    chk("rerun_valid", {31'b0, if_valid}, 32'h1);
    chk("rerun_pc", if_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
